seq_comparator: RTL
===================

SEQ_COMPARATOR -- requirements
Module: seq_comparator

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits.
REQ-002 SHALL have parameter CHUNK, default 4, bits compared per cycle; WIDTH % CHUNK == 0 required; N = WIDTH/CHUNK.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operand pair offered.
REQ-006 SHALL have port in_ready  output  1  block can accept an operand pair.
REQ-007 SHALL have port a  input  WIDTH  operand A.
REQ-008 SHALL have port b  input  WIDTH  operand B.
REQ-009 SHALL have port signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled with operands.
REQ-010 SHALL have port out_valid  output  1  result available.
REQ-011 SHALL have port out_ready  input  1  consumer takes result.
REQ-012 SHALL have ports a_gt_b, a_eq_b, a_lt_b  output  1 each  result flags.

Function
REQ-013 SHALL implement FSM states IDLE, CMP, DONE; in_ready = 1 only in IDLE with rst low.
REQ-014 IDLE: on in_valid && in_ready at an edge, SHALL register a, b, signed_mode, set chunk index to 0 (MSB chunk), go to CMP.
REQ-015 Operand or signed_mode changes after acceptance SHALL have no effect on the result.
REQ-016 CMP: each cycle SHALL unsigned-compare chunk idx of A and B (idx 0 = bits WIDTH-1..WIDTH-CHUNK); in signed mode the MSB of chunk 0 of both operands is inverted before the compare.
REQ-017 CMP: if the chunks differ, SHALL latch gt/lt accordingly and go to DONE (early termination).
REQ-018 CMP: if the chunks are equal and idx == N-1, SHALL latch eq and go to DONE; otherwise idx increments and the FSM stays in CMP.
REQ-019 Latency: with k = chunks examined (1..N), out_valid SHALL rise exactly k edges after the accepting edge.
REQ-020 DONE: out_valid = 1, exactly one flag high, all held stable until out_ready is sampled high.
REQ-021 DONE with out_ready high: SHALL go to IDLE; in_ready rises the following cycle (one bubble cycle, no same-cycle accept).
REQ-022 When out_valid = 0, a_gt_b, a_eq_b and a_lt_b SHALL all be 0.
REQ-023 in_valid outside IDLE and out_ready outside DONE SHALL be ignored.

Reset
REQ-024 rst high SHALL immediately force state IDLE, idx 0, out_valid 0, all flags 0, in_ready 0.
REQ-025 rst asserted mid-CMP or in DONE SHALL discard the operation with no result emitted.
REQ-026 The first accept SHALL be possible at the first edge after rst deasserts.

Structure
REQ-027 A shared package comparator_pkg SHALL hold the FSM state enum and the result encoding constants (GT, EQ, LT).
REQ-028 The per-cycle CHUNK-bit unsigned compare SHALL be a sub-module chunk_cmp (inputs x, y; outputs gt, eq, lt); sign handling stays in seq_comparator.

Verification (WIDTH=16, CHUNK=4)
REQ-029 a=0x1234, b=0x1234, unsigned -> a_eq_b=1, out_valid 4 edges after accept.
REQ-030 a=0x9000, b=0x1000: unsigned -> a_gt_b=1 after 1 edge; signed -> a_lt_b=1 after 1 edge.
REQ-031 a=0x12A4, b=0x1294, unsigned -> a_gt_b=1 after 3 edges; a=0xFFFF, b=0x0001, signed -> a_lt_b=1 after 1 edge.
REQ-032 Hold out_ready=0 for 5 cycles in DONE with in_valid=1 -> out_valid and flags stable, in_ready=0, no accept; out_ready=1 -> one idle bubble cycle, then accept.
REQ-033 Assert rst during the 2nd CMP cycle -> out_valid, flags and in_ready go to 0 without a clock edge; after release a fresh compare completes correctly.

Source files
------------

// File: rtl/comparator_pkg.sv
//-----------------------------------------------------------------------------
// comparator_pkg
//
// Shared definitions for the sequential magnitude comparator:
//   state_t   - control FSM states (IDLE, CMP, DONE)
//   result_t  - one-hot result word, bit order {gt, eq, lt}
//   GT/EQ/LT  - the three legal result encodings
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

package comparator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // waiting for an operand pair
    CMP  = 2'd1,  // walking chunks from MSB towards LSB
    DONE = 2'd2   // result presented until the consumer takes it
  } state_t;

  // Result word maps directly onto the {a_gt_b, a_eq_b, a_lt_b} outputs.
  typedef logic [2:0] result_t;

  localparam result_t GT = 3'b100;
  localparam result_t EQ = 3'b010;
  localparam result_t LT = 3'b001;

endpackage : comparator_pkg

// File: rtl/chunk_cmp.sv
//-----------------------------------------------------------------------------
// chunk_cmp
//
// Purely combinational unsigned compare of two W-bit slices. Exactly one of
// gt/eq/lt is high for any input pair. Signed handling is done by the caller,
// which pre-conditions the slice MSBs before they reach this block.
//
// Ports:
//   x, y       - W-bit unsigned operands
//   gt, eq, lt - x > y, x == y, x < y
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module chunk_cmp #(
  parameter int W = 4
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic         gt,
  output logic         eq,
  output logic         lt
);

  assign gt = (x > y);
  assign eq = (x == y);
  assign lt = (x < y);

endmodule : chunk_cmp

// File: rtl/seq_comparator.sv
//-----------------------------------------------------------------------------
// seq_comparator
//
// Multi-cycle magnitude comparator. An accepted operand pair is examined
// CHUNK bits per cycle starting at the most significant chunk; the first
// differing chunk decides the result immediately (early termination). If all
// N = WIDTH/CHUNK chunks match the operands are equal. The result is held in
// DONE until the consumer takes it, after which one idle cycle passes before
// the next pair can be accepted.
//
// Signed mode: inverting the sign bit of both operands maps two's-complement
// order onto unsigned order, so only chunk 0 needs adjusting and the chunk
// compare itself stays unsigned.
//
// Ports:
//   clk, rst            - clock; asynchronous active-high reset
//   in_valid, in_ready  - operand handshake (in_ready only in IDLE, rst low)
//   a, b                - WIDTH-bit operands
//   signed_mode         - 1: two's-complement compare, 0: unsigned
//   out_valid, out_ready- result handshake
//   a_gt_b/a_eq_b/a_lt_b- one-hot result flags, all zero while out_valid = 0
//
// WIDTH must be a multiple of CHUNK.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module seq_comparator
  import comparator_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             a_gt_b,
  output logic             a_eq_b,
  output logic             a_lt_b
);

  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  state_t state;
  state_t state_nxt;

  // Operand copies are shifted left by CHUNK each CMP cycle so the chunk
  // under test always sits in the top CHUNK bits; no wide index mux needed.
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             sgn_q;
  logic [IDX_W-1:0] idx;
  result_t          res_q;

  logic [CHUNK-1:0] chunk_a;
  logic [CHUNK-1:0] chunk_b;
  logic             c_gt;
  logic             c_eq;
  logic             c_lt;
  logic             last_chunk;
  logic             accept;

  assign accept     = in_valid && in_ready;
  assign last_chunk = (idx == IDX_W'(N - 1));

  //---------------------------------------------------------------------------
  // Chunk selection and sign conditioning
  //---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable assigned in a combinational block gets a value on
    // every path (defaults first), otherwise synthesis infers a latch.
    chunk_a = a_sh[WIDTH-1 -: CHUNK];
    chunk_b = b_sh[WIDTH-1 -: CHUNK];
    if (sgn_q && (idx == '0)) begin
      chunk_a[CHUNK-1] = ~chunk_a[CHUNK-1];
      chunk_b[CHUNK-1] = ~chunk_b[CHUNK-1];
    end
  end

  chunk_cmp #(
    .W (CHUNK)
  ) u_chunk_cmp (
    .x  (chunk_a),
    .y  (chunk_b),
    .gt (c_gt),
    .eq (c_eq),
    .lt (c_lt)
  );

  //---------------------------------------------------------------------------
  // FSM: state register
  //---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: clocked state uses non-blocking (<=) so every register samples the
    // pre-edge values of the others; blocking here creates ordering races.
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  //---------------------------------------------------------------------------
  // FSM: next-state logic
  //---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = CMP;
      CMP:  if (!c_eq || last_chunk) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  //---------------------------------------------------------------------------
  // FSM: outputs
  //---------------------------------------------------------------------------
  always_comb begin
    // rst gates in_ready directly so nothing is offered while reset is held,
    // even though the async reset has already parked the FSM in IDLE.
    in_ready  = (state == IDLE) && !rst;
    out_valid = (state == DONE);
    {a_gt_b, a_eq_b, a_lt_b} = out_valid ? res_q : '0;
  end

  //---------------------------------------------------------------------------
  // Datapath: operand capture, chunk walk and result latch
  //---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      sgn_q <= 1'b0;
      idx   <= '0;
      res_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            a_sh  <= a;
            b_sh  <= b;
            sgn_q <= signed_mode;
            idx   <= '0;
          end
        end
        CMP: begin
          a_sh <= a_sh << CHUNK;
          b_sh <= b_sh << CHUNK;
          idx  <= idx + IDX_W'(1);
          if (c_gt) begin
            res_q <= GT;
          end else if (c_lt) begin
            res_q <= LT;
          end else if (last_chunk) begin
            res_q <= EQ;
          end
        end
        default: ;
      endcase
    end
  end

endmodule : seq_comparator
